// File: rtl/universal_shift_reg_if.sv
// rtl/universal_shift_reg_if.sv - request/result bundle for universal_shift_reg
//
// Purpose: groups the operation request and result signals of the shift engine.
// Signals:
//   start_i   request, sampled only while the engine is idle
//   op_i      3-bit operation code, captured with start_i
//   shamt_i   shift count 0..N-1, captured with start_i
//   data_i    N-bit operand, captured with start_i
//   serial_i  serial bit shifted into the LSB by op SIN
//   data_o    shift register contents
//   serial_o  bit shifted out by the most recent shift
//   busy_o    high whenever the engine is not idle
//   done_o    one-cycle completion pulse
// Modports: master drives the request side, slave is the shift engine.
interface universal_shift_reg_if #(
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic          start_i;
  logic [2:0]    op_i;
  logic [SW-1:0] shamt_i;
  logic [N-1:0]  data_i;
  logic          serial_i;
  logic [N-1:0]  data_o;
  logic          serial_o;
  logic          busy_o;
  logic          done_o;

  modport master (
    output start_i, op_i, shamt_i, data_i, serial_i,
    input  data_o, serial_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, shamt_i, data_i, serial_i,
    output data_o, serial_o, busy_o, done_o
  );
endinterface

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - multi-cycle universal shift/rotate register
//
// Purpose: captures an operand and performs shamt one-bit shifts, one per
// cycle, of the selected kind (logical, arithmetic, rotate, serial-in).
// Ports:
//   clk_i  system clock, all state updates on the rising edge
//   rst_i  synchronous active-high reset
//   bus    universal_shift_reg_if.slave (request in, result/status out)
module universal_shift_reg #(
  parameter int N = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  universal_shift_reg_if.slave  bus
);
  localparam int SW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_SIN  = 3'b110;
  localparam logic [2:0] OP_HOLD = 3'b111;

  logic [1:0]    state;
  logic [2:0]    op_q;
  logic [SW-1:0] cnt;
  logic [N-1:0]  sreg;
  logic          sout;

  logic [N-1:0]  shifted;
  logic          shift_bit;

  // One-bit step of the captured operation. LOAD and HOLD step as identity,
  // so a nonzero count for them only spends time without altering the data.
  always_comb begin
    shifted   = sreg;
    shift_bit = sout;
    case (op_q)
      OP_SLL: begin
        shifted   = {sreg[N-2:0], 1'b0};
        shift_bit = sreg[N-1];
      end
      OP_SRL: begin
        shifted   = {1'b0, sreg[N-1:1]};
        shift_bit = sreg[0];
      end
      OP_SRA: begin
        shifted   = {sreg[N-1], sreg[N-1:1]};
        shift_bit = sreg[0];
      end
      OP_ROL: begin
        shifted   = {sreg[N-2:0], sreg[N-1]};
        shift_bit = sreg[N-1];
      end
      OP_ROR: begin
        shifted   = {sreg[0], sreg[N-1:1]};
        shift_bit = sreg[0];
      end
      OP_SIN: begin
        shifted   = {sreg[N-2:0], bus.serial_i};
        shift_bit = sreg[N-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      op_q  <= OP_LOAD;
      cnt   <= '0;
      sreg  <= '0;
      sout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            // HOLD keeps both the register and the last shifted-out bit.
            if (bus.op_i != OP_HOLD) begin
              sreg <= bus.data_i;
              sout <= 1'b0;
            end
            op_q  <= bus.op_i;
            cnt   <= bus.shamt_i;
            state <= (bus.shamt_i != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          sreg <= shifted;
          sout <= shift_bit;
          // Saturate at zero; the counter never wraps.
          if (cnt != '0) cnt <= cnt - SW'(1);
          if (cnt <= SW'(1)) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_o   = sreg;
  assign bus.serial_o = sout;
  assign bus.busy_o   = (state != S_IDLE);
  assign bus.done_o   = (state == S_DONE);
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter N, default 8: data width in bits, legal range 2..64.
REQ-002 SHALL have derived localparam SW = $clog2(N): width of the shift-amount field.
REQ-003 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op_i  input  3  operation code; captured with start_i.
REQ-007 SHALL have port shamt_i  input  SW  shift count, 0..N-1; captured with start_i.
REQ-008 SHALL have port data_i  input  N  operand; captured with start_i.
REQ-009 SHALL have port serial_i  input  1  serial bit for op SIN; sampled every RUN cycle.
REQ-010 SHALL have port data_o  output  N  shift register contents.
REQ-011 SHALL have port serial_o  output  1  bit shifted out by the most recent shift.
REQ-012 SHALL have port busy_o  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port done_o  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL decode op_i as follows:
- 000 LOAD
- 001 SLL: shift left logical, zero fill at the LSB.
- 010 SRL: shift right logical, zero fill at the MSB.
- 011 SRA: shift right arithmetic, MSB replicated.
- 100 ROL: rotate left.
- 101 ROR: rotate right.
- 110 SIN: shift left with serial_i entering the LSB.
- 111 HOLD: data_o stays unchanged; the capture and shifts of REQ-016/REQ-017 SHALL NOT occur.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL, in IDLE with start_i=1, capture data_i into the register, capture op_i, load the counter with shamt_i, and clear serial_o.
- Next state is RUN if shamt_i>0, otherwise DONE.
REQ-017 SHALL, in RUN, perform exactly one 1-bit shift per cycle and decrement the counter.
- Moves to DONE after the shamt-th shift.
REQ-018 SHALL set serial_o on each shift to the departing bit:
- the old MSB for SLL, ROL and SIN;
- the old LSB for SRL, SRA and ROR.
REQ-019 SHALL, in DONE, assert done_o for exactly one cycle and return to IDLE on the next cycle.
REQ-020 SHALL meet this latency: for start sampled at edge t, the final data_o and done_o=1 appear together in cycle t+1+shamt.
REQ-021 SHALL ignore start_i while in RUN or DONE.
- Back-to-back throughput is therefore shamt+2 cycles per operation.
REQ-022 SHALL hold data_o and serial_o stable in IDLE and DONE.
REQ-023 SHALL keep the counter SW bits wide and SHALL NOT wrap below zero.
- shamt values of N or more cannot be encoded and need no handling.

Reset
REQ-024 SHALL, when rst_i=1 at a rising clock edge, force the following, overriding any state including mid-RUN:
- state = IDLE;
- data_o = 0, serial_o = 0, busy_o = 0, done_o = 0;
- counter = 0.
REQ-025 SHALL ignore start_i in any cycle where rst_i=1.

Verification (N=8)
REQ-026 SHALL cover SLL: data 8'b1011_0011, shamt 3 -> data_o 8'b1001_1000, serial_o 1, done_o in cycle t+4, busy_o high cycles t+1..t+4.
REQ-027 SHALL cover SRA vs SRL: data 8'h90, shamt 2 -> SRA gives 8'hE4, SRL gives 8'h24, serial_o 0 in both.
REQ-028 SHALL cover ROR: data 8'h81, shamt 1 -> 8'hC0, serial_o 1. ROL with data 8'h81, shamt 7 -> 8'hC0.
REQ-029 SHALL cover LOAD and zero shift: LOAD with 8'h5A, or SLL with shamt 0 -> data_o 8'h5A, done_o in cycle t+1. HOLD with data_o initially 8'h5A -> data_o stays 8'h5A, done_o in cycle t+1.
REQ-030 SHALL cover SIN: data 8'h00, shamt 4, serial_i sequence 1,0,1,1 -> 8'h0B.
REQ-031 SHALL cover the boundary cases:
- start_i pulsed mid-RUN -> ignored, original result unchanged;
- rst_i asserted mid-RUN -> all outputs 0 next cycle, no done_o pulse.
